// File: rtl/write_back_stage_pkg.sv
// write_back_stage_pkg: shared encodings for the LC3 write-back stage.
package write_back_stage_pkg;
    localparam int NUM_REGS = 8;
    localparam int REG_AW = $clog2(NUM_REGS);
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC = 2'd2;
    localparam logic [1:0] WB_NPC = 2'd3;
    localparam int PSR_N = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_P = 0;
    localparam logic [2:0] PSR_RESET = 3'b000;
endpackage

// File: rtl/write_back_regfile.sv
// write_back_regfile: 8-entry register file, one write port, two async read ports with optional forwarding.
module write_back_regfile
    import write_back_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) regs_q <= '{default: '0};
        else if (we) regs_q[waddr] <= wdata;
    end
    // Forwarding lets execute see this cycle's commit without waiting for the edge.
    assign rdata1 = (BYPASS != 0 && we && raddr1 == waddr) ? wdata : regs_q[raddr1];
    assign rdata2 = (BYPASS != 0 && we && raddr2 == waddr) ? wdata : regs_q[raddr2];
endmodule

// File: rtl/write_back_stage.sv
// write_back_stage: selects the result source, commits it to the register file and updates N/Z/P.
module write_back_stage
    import write_back_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_writeback,
    input  logic [1:0]        W_Control,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] memout,
    input  logic [DATA_W-1:0] pcout,
    input  logic [DATA_W-1:0] npc,
    input  logic [2:0]        dr,
    input  logic [2:0]        sr1,
    input  logic [2:0]        sr2,
    output logic [DATA_W-1:0] VSR1,
    output logic [DATA_W-1:0] VSR2,
    output logic [2:0]        psr
);
    logic [DATA_W-1:0] dr_in;
    logic [2:0] psr_d, psr_q;
    logic is_zero;
    always_comb begin
        dr_in = (W_Control == WB_ALU) ? aluout :
                (W_Control == WB_MEM) ? memout :
                (W_Control == WB_PC)  ? pcout  : npc;
        is_zero = (dr_in == '0);
        psr_d = psr_q;
        if (enable_writeback) begin
            psr_d[PSR_N] = dr_in[DATA_W-1];
            psr_d[PSR_Z] = is_zero;
            psr_d[PSR_P] = !dr_in[DATA_W-1] && !is_zero;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) psr_q <= PSR_RESET;
        else psr_q <= psr_d;
    end
    assign psr = psr_q;
    write_back_regfile #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_regfile (
        .clock  (clock),
        .reset  (reset),
        .we     (enable_writeback),
        .waddr  (dr),
        .wdata  (dr_in),
        .raddr1 (sr1),
        .raddr2 (sr2),
        .rdata1 (VSR1),
        .rdata2 (VSR2)
    );
endmodule

// File: tb/tb_write_back_stage.sv
// tb_write_back_stage: scoreboard bench for the write-back stage, forwarding and non-forwarding builds.
module tb_write_back_stage;
    logic clock = 0, reset = 0, enable_writeback = 0;
    logic [1:0] W_Control = 0;
    logic [15:0] aluout = 0, memout = 0, pcout = 0, npc = 0;
    logic [2:0] dr = 0, sr1 = 0, sr2 = 0, psr, psr_nb;
    logic [15:0] VSR1, VSR2, VSR1_nb, VSR2_nb;
    int checks = 0, errors = 0;
    logic [15:0] mdl [8];
    logic [2:0] mdl_psr;
    typedef struct { logic [2:0] r; logic [15:0] val; logic [2:0] cc; } exp_t;
    exp_t sb [$];

    always #5 clock = ~clock;

    write_back_stage #(.DATA_W(16), .BYPASS(1)) dut (
        .clock(clock), .reset(reset), .enable_writeback(enable_writeback), .W_Control(W_Control),
        .aluout(aluout), .memout(memout), .pcout(pcout), .npc(npc), .dr(dr), .sr1(sr1), .sr2(sr2),
        .VSR1(VSR1), .VSR2(VSR2), .psr(psr));
    write_back_stage #(.DATA_W(16), .BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset), .enable_writeback(enable_writeback), .W_Control(W_Control),
        .aluout(aluout), .memout(memout), .pcout(pcout), .npc(npc), .dr(dr), .sr1(sr1), .sr2(sr2),
        .VSR1(VSR1_nb), .VSR2(VSR2_nb), .psr(psr_nb));

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v == 16'h0000) return 3'b010;
        if (v > 16'h7FFF) return 3'b100;
        return 3'b001;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        mdl_psr = 3'b000;
    endtask

    // Unselected operands carry random junk to show they never reach the register file.
    task automatic drive(input logic en, input logic [1:0] wc, input logic [15:0] v, input logic [2:0] d);
        enable_writeback = en; W_Control = wc; dr = d;
        aluout = 16'($urandom); memout = 16'($urandom); pcout = 16'($urandom); npc = 16'($urandom);
        case (wc)
            2'd0: aluout = v;
            2'd1: memout = v;
            2'd2: pcout = v;
            default: npc = v;
        endcase
    endtask

    task automatic step(input string tag, input logic en, input logic [1:0] wc, input logic [15:0] v, input logic [2:0] d);
        exp_t e;
        drive(en, wc, v, d);
        if (en) begin mdl[d] = v; mdl_psr = cc_of(v); end
        sb.push_back('{d, mdl[d], mdl_psr});
        @(posedge clock); #1;
        enable_writeback = 0;
        e = sb.pop_front();
        sr1 = e.r; sr2 = e.r; #1;
        check({tag, "_vsr1"}, VSR1, e.val);
        check({tag, "_vsr2_nb"}, VSR2_nb, e.val);
        check({tag, "_psr"}, {13'b0, psr}, {13'b0, e.cc});
        check({tag, "_psr_nb"}, {13'b0, psr_nb}, {13'b0, e.cc});
    endtask

    initial begin
        clear_model();
        sr1 = 3'd3; #1;
        check("rst_vsr1", VSR1, 16'h0000);
        check("rst_psr", {13'b0, psr}, 16'h0000);
        #11 reset = 1;
        step("w_r3", 1, 2'd0, 16'h1234, 3'd3);
        #2 reset = 0; sr1 = 3'd3; #1;
        check("async_rst_vsr1", VSR1, 16'h0000);
        check("async_rst_psr", {13'b0, psr}, 16'h0000);
        drive(1, 2'd0, 16'h5555, 3'd3);
        @(posedge clock); #1;
        enable_writeback = 0; sr1 = 3'd3; #1;
        check("rst_wins_vsr1", VSR1_nb, 16'h0000);
        clear_model();
        reset = 1;
        step("hold_after_rst", 0, 2'd1, 16'h7777, 3'd3);
        step("alu_r5", 1, 2'd0, 16'h8001, 3'd5);
        step("mem_r2", 1, 2'd1, 16'h0000, 3'd2);
        step("npc_r7", 1, 2'd3, 16'h3001, 3'd7);
        step("pc_r1_set", 1, 2'd2, 16'h0042, 3'd1);
        step("disabled_r1", 0, 2'd2, 16'hFFFF, 3'd1);
        step("r4_old", 1, 2'd0, 16'h0101, 3'd4);
        drive(1, 2'd0, 16'h00AA, 3'd4);
        sr1 = 3'd4; sr2 = 3'd4; #1;
        check("byp_vsr1", VSR1, 16'h00AA);
        check("byp_vsr2", VSR2, 16'h00AA);
        check("nobyp_vsr1", VSR1_nb, mdl[4]);
        check("nobyp_vsr2", VSR2_nb, mdl[4]);
        step("byp_commit", 1, 2'd0, 16'h00AA, 3'd4);
        step("b2b_r6_a", 1, 2'd0, 16'h0001, 3'd6);
        step("b2b_r6_b", 1, 2'd1, 16'hFFFE, 3'd6);
        for (int i = 0; i < 24; i++)
            step("rand", 1'($urandom), 2'($urandom), (i % 5 == 0) ? 16'h0000 : 16'($urandom), 3'($urandom));
        for (int i = 0; i < 8; i++) begin
            sr1 = 3'(i); sr2 = 3'(7 - i); #1;
            check("final_vsr1", VSR1, mdl[i]);
            check("final_vsr2", VSR2, mdl[7 - i]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
